// File: rtl/shift_arb_ctrl.sv
// Round-robin arbiter sharing one MSB-first serial shift channel between two
// parallel-word requesters, with framing, per-bit strobe and completion pulse.
module shift_arb_ctrl #(
    parameter int WIDTH   = 8,
    parameter int BIT_DIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             sout,
    output logic             sframe,
    output logic             sstrobe,
    output logic             src_id,
    output logic             done,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int DW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] BIT_ONE  = CW'(1);
    localparam logic [DW-1:0] DIV_LAST = DW'(BIT_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] shreg_r;
    logic [CW-1:0]    bit_cnt_r;
    logic [DW-1:0]    div_cnt_r;
    logic             last_grant_r;
    logic             src_id_r;
    logic             sout_r;
    logic             sframe_r;
    logic             sstrobe_r;
    logic             done_r;
    logic             busy_r;

    logic             grant_s;
    logic             idle_s;
    logic             ready0_s;
    logic             ready1_s;
    logic             load_s;
    logic [WIDTH-1:0] load_data_s;

    // Round-robin pick: on a tie the requester that did not win last time goes.
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_s = ~last_grant_r;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    assign idle_s      = (state_r == ST_IDLE);
    assign ready0_s    = req0_valid & ~grant_s & idle_s;
    assign ready1_s    = req1_valid &  grant_s & idle_s;
    assign load_s      = ready0_s | ready1_s;
    assign load_data_s = grant_s ? req1_data : req0_data;

    // Frame sequencer; outputs are registered alongside the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            shreg_r      <= {WIDTH{1'b0}};
            bit_cnt_r    <= {CW{1'b0}};
            div_cnt_r    <= {DW{1'b0}};
            last_grant_r <= 1'b1;
            src_id_r     <= 1'b0;
            sout_r       <= 1'b0;
            sframe_r     <= 1'b0;
            sstrobe_r    <= 1'b0;
            done_r       <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (load_s) begin
                        state_r      <= ST_SHIFT;
                        shreg_r      <= load_data_s;
                        bit_cnt_r    <= {CW{1'b0}};
                        div_cnt_r    <= {DW{1'b0}};
                        last_grant_r <= grant_s;
                        src_id_r     <= grant_s;
                        sout_r       <= load_data_s[WIDTH-1];
                        sframe_r     <= 1'b1;
                        sstrobe_r    <= 1'b1;
                        busy_r       <= 1'b1;
                    end else begin
                        sout_r    <= 1'b0;
                        sframe_r  <= 1'b0;
                        sstrobe_r <= 1'b0;
                        busy_r    <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (div_cnt_r == DIV_LAST) begin
                        if (bit_cnt_r < BIT_LAST) begin
                            // Next bit becomes MSB; sout shows it from the next cycle.
                            shreg_r   <= {shreg_r[WIDTH-2:0], 1'b0};
                            bit_cnt_r <= bit_cnt_r + BIT_ONE;
                            div_cnt_r <= {DW{1'b0}};
                            sout_r    <= shreg_r[WIDTH-2];
                            sframe_r  <= 1'b1;
                            sstrobe_r <= 1'b1;
                        end else begin
                            state_r   <= ST_DONE;
                            sout_r    <= 1'b0;
                            sframe_r  <= 1'b0;
                            sstrobe_r <= 1'b0;
                            done_r    <= 1'b1;
                        end
                    end else begin
                        div_cnt_r <= div_cnt_r + DIV_ONE;
                        sout_r    <= shreg_r[WIDTH-1];
                        sframe_r  <= 1'b1;
                        sstrobe_r <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_r   <= ST_IDLE;
                    done_r    <= 1'b0;
                    busy_r    <= 1'b0;
                    sout_r    <= 1'b0;
                    sframe_r  <= 1'b0;
                    sstrobe_r <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    done_r    <= 1'b0;
                    busy_r    <= 1'b0;
                    sout_r    <= 1'b0;
                    sframe_r  <= 1'b0;
                    sstrobe_r <= 1'b0;
                end
            endcase
        end
    end

    assign req0_ready = ready0_s;
    assign req1_ready = ready1_s;
    assign sout       = sout_r;
    assign sframe     = sframe_r;
    assign sstrobe    = sstrobe_r;
    assign src_id     = src_id_r;
    assign done       = done_r;
    assign busy       = busy_r;

endmodule

// File: doc/shift_arb_ctrl.md
# shift_arb_ctrl

Round-robin controller that shares one MSB-first serial shift channel between two parallel-word requesters. Each accepted word is loaded into an internal WIDTH-bit shift register and clocked out one bit per BIT_DIV cycles, with framing, per-bit strobe and completion outputs. It sits between the parallel producers and the serial pin or link, and is the only block that loads or shifts the serial register.

## Interface

- WIDTH, 8: bits per frame; legal range is 2 or more.
- BIT_DIV, 1: clock cycles each bit is held on sout; legal range is 1 or more.
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a word.
- req0_data  in  WIDTH  requester 0 word.
- req0_ready  out  1  requester 0 word accepted this cycle.
- req1_valid  in  1  requester 1 has a word.
- req1_data  in  WIDTH  requester 1 word.
- req1_ready  out  1  requester 1 word accepted this cycle.
- sout  out  1  serial data, MSB first.
- sframe  out  1  high while sout carries a frame bit.
- sstrobe  out  1  one-cycle pulse in the first cycle of each bit.
- src_id  out  1  requester that owns the current or just-completed frame.
- done  out  1  one-cycle pulse after the last bit of a frame.
- busy  out  1  high in any state other than IDLE.

## Operation

- The FSM has three states: IDLE, SHIFT and DONE. The reset state is IDLE.
- **IDLE**
  - Arbitration is round-robin. The last_grant register resets to 1, so requester 0 wins the first tie.
  - When exactly one request is valid, that requester is granted.
  - When both are valid, the requester not equal to last_grant is granted.
  - reqN_ready is combinational: it equals reqN_valid AND grant-to-N AND state==IDLE. At most one ready is high in any cycle.
  - A handshake occurs when valid and ready are both high. On the next edge:
    - the shift register loads the granted data;
    - src_id and last_grant take the granted index;
    - the bit counter and divider counter clear;
    - the state moves to SHIFT.
- **SHIFT**
  - sout = shreg[WIDTH-1] and sframe=1.
  - The divider counts 0..BIT_DIV-1. sstrobe=1 when the divider is 0.
  - When the divider reaches BIT_DIV-1:
    - if the bit counter is below WIDTH-1, shreg shifts left with 0 fill, the bit counter increments and the divider clears;
    - otherwise the state moves to DONE.
- **DONE**
  - Lasts exactly one cycle. done=1, sframe=0, sout=0, both readies 0, src_id held.
  - The state then returns to IDLE.
- Outside SHIFT, sout=0, sframe=0 and sstrobe=0.
- A requester may drop valid without a handshake; this has no effect. Data is sampled only on the handshake.
- reqN_data is ignored in all other cycles. Changes during SHIFT do not alter the frame in flight.
- Requests arriving during SHIFT or DONE wait; no request is lost while valid is held.
- Counter widths are clog2 of WIDTH and clog2 of BIT_DIV, with a minimum of 1 bit. There is no wrap-around beyond the terminal counts.

## Timing

- **Reset:** rst low forces the following immediately and asynchronously, including mid-frame:
  - state=IDLE;
  - shreg, counters, sout, sframe, sstrobe, done, busy and src_id all 0;
  - last_grant=1.
  - A partial frame is abandoned and is not resumed. Readies depend on valid after release.
- **Frame latency:** for a handshake in cycle T:
  - bit k (MSB = bit 0) is on sout in cycles T+1+k*BIT_DIV through T+(k+1)*BIT_DIV;
  - sframe is high from T+1 through T+WIDTH*BIT_DIV;
  - done is high in cycle T+WIDTH*BIT_DIV+1;
  - the earliest next handshake is T+WIDTH*BIT_DIV+2.
- **Throughput:** one frame per WIDTH*BIT_DIV+2 cycles under continuous requests.
- busy is high from T+1 through T+WIDTH*BIT_DIV+1.
- **Simultaneous valids in IDLE:** ownership alternates strictly, 0,1,0,1...
- A valid that rises in the DONE cycle is granted in the following IDLE cycle.

## Test plan

- **Single frame, defaults:** reset, then req0_valid=1 with data 0xA5 for one cycle.
  - Required: req0_ready=1 that cycle.
  - sout over the next 8 cycles is 1,0,1,0,0,1,0,1 with sframe=1.
  - done=1 in the 9th cycle and src_id=0.
- **BIT_DIV=3, WIDTH=8, req1 data 0x81:**
  - Required: sout=1 for cycles 1-3, 0 for cycles 4-21, 1 for cycles 22-24.
  - sstrobe pulses at cycles 1,4,...,22.
  - done at cycle 25.
- **Contention:** both valids held high with req0 data 0x0F and req1 data 0xF0 for 4 frames.
  - Required: grants go 0,1,0,1, and src_id matches each frame.
  - Frames start 10 cycles apart and readies are never both high.
- **Late request:** req1_valid rises during SHIFT of a req0 frame.
  - Required: req1_ready stays 0 until IDLE, then the req1 frame follows with no loss.
- **Reset mid-frame:** assert rst low after 3 bits of 0xFF.
  - Required: sout, sframe and busy go to 0 immediately, with no done pulse.
  - After release with req1 and req0 valid together, req0 is granted first.
- **Withdrawn request:** req0_valid is high for one IDLE cycle while req1 holds the grant, then drops.
  - Required: no req0 handshake and no frame from req0.
